// File: rtl/opseq_pkg.sv
// Shared types and constants for the operand load sequencer.
// The optional repeat-last-value entry path is enabled with OPSEQ_REPEAT_EN.
package opseq_pkg;

  localparam int OPSEQ_W     = 9;
  localparam int OPSEQ_ELEMS = 9;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/operand_load_sequencer_if.sv
// Entry, register-file write and ALU handshake bundle of the operand load sequencer.
// repeat_last exists only when OPSEQ_REPEAT_EN is defined.
interface operand_load_sequencer_if #(
  parameter int W     = opseq_pkg::OPSEQ_W,
  parameter int ELEMS = opseq_pkg::OPSEQ_ELEMS
);
  localparam int IW = $clog2(ELEMS);

  logic          begin_op;
  logic          enter;
  logic          clear;
  logic [W-1:0]  op_in;
  logic          alu_done;
`ifdef OPSEQ_REPEAT_EN
  logic          repeat_last;
`endif
  logic          wr_en;
  logic          wr_sel;
  logic [IW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          alu_start;
  logic          result_valid;
  logic          busy;
  logic [2:0]    state_o;

  // The sequencer side drives the write bus and status.
  modport master (
    input  begin_op, enter, clear, op_in, alu_done,
`ifdef OPSEQ_REPEAT_EN
    input  repeat_last,
`endif
    output wr_en, wr_sel, wr_addr, wr_data, alu_start, result_valid, busy, state_o
  );

  modport slave (
    output begin_op, enter, clear, op_in, alu_done,
`ifdef OPSEQ_REPEAT_EN
    output repeat_last,
`endif
    input  wr_en, wr_sel, wr_addr, wr_data, alu_start, result_valid, busy, state_o
  );

endinterface

// File: rtl/opseq_idx_counter.sv
// Element index counter: counts 0..ELEMS-1 on inc, wraps to 0, and flags the wrap.
module opseq_idx_counter #(
  parameter int ELEMS = 9,
  localparam int IW   = $clog2(ELEMS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [IW-1:0] idx,
  output logic          wrap
);

  localparam logic [IW-1:0] LAST = IW'(ELEMS - 1);

  assign wrap = inc && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx <= '0;
    else if (clr)
      idx <= '0;
    else if (inc)
      idx <= wrap ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/operand_load_sequencer.sv
// Sequences operand entry into matrix A then B, launches the ALU and holds result_valid.
// Defining OPSEQ_REPEAT_EN adds repeat_last, which re-writes the last entered value.
module operand_load_sequencer
  import opseq_pkg::*;
#(
  parameter int W     = OPSEQ_W,
  parameter int ELEMS = OPSEQ_ELEMS
) (
  input logic clk,
  input logic rst,
  operand_load_sequencer_if.master bus
);

  localparam int IW = $clog2(ELEMS);

  state_t        state, next_state;
  logic [IW-1:0] idx;
  logic          wrap;
  logic          loading;
  logic          commit;
  logic          idx_clr;
  logic [W-1:0]  commit_data;

`ifdef OPSEQ_REPEAT_EN
  logic [W-1:0]  last_val;
`endif

  // A commit is one element write; clear always wins so an aborted entry never lands.
  always_comb begin
    loading = (state == LOAD_A) || (state == LOAD_B);
`ifdef OPSEQ_REPEAT_EN
    commit      = loading && !bus.clear && (bus.enter || bus.repeat_last);
    commit_data = bus.enter ? bus.op_in : last_val;
`else
    commit      = loading && !bus.clear && bus.enter;
    commit_data = bus.op_in;
`endif
    idx_clr = bus.clear || (bus.begin_op && (state == IDLE || state == DONE));
  end

  opseq_idx_counter #(.ELEMS(ELEMS)) u_idx (
    .clk  (clk),
    .rst  (rst),
    .inc  (commit),
    .clr  (idx_clr),
    .idx  (idx),
    .wrap (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.begin_op) next_state = LOAD_A;
        LOAD_A:  if (commit && wrap) next_state = LOAD_B;
        LOAD_B:  if (commit && wrap) next_state = START;
        START:   next_state = WAIT;
        WAIT:    if (bus.alu_done) next_state = DONE;
        DONE:    if (bus.begin_op) next_state = LOAD_A;
        default: next_state = IDLE;
      endcase
    end
  end

  // Status outputs decode the registered state, so they are glitch-free and reset to 0.
  always_comb begin
    bus.alu_start    = (state == START);
    bus.result_valid = (state == DONE);
    bus.busy         = (state != IDLE);
    bus.state_o      = state;
  end

  // Write port lags enter by one cycle; address/data/select hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_sel  <= SEL_A;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= commit;
      if (commit) begin
        bus.wr_sel  <= (state == LOAD_B) ? SEL_B : SEL_A;
        bus.wr_addr <= idx;
        bus.wr_data <= commit_data;
      end
    end
  end

`ifdef OPSEQ_REPEAT_EN
  // Only real entries update the remembered value; it survives the A->B hand-over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_val <= '0;
    else if (commit && bus.enter)
      last_val <= bus.op_in;
  end
`endif

endmodule

// File: tb/tb_operand_load_sequencer.sv
// Self-checking bench for operand_load_sequencer: directed scenarios plus random traffic
// compared every cycle against a count-based reference model (OPSEQ_REPEAT_EN aware).
module tb_operand_load_sequencer;
  import opseq_pkg::*;

  localparam int W     = OPSEQ_W;
  localparam int ELEMS = OPSEQ_ELEMS;
`ifdef OPSEQ_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_load_sequencer_if bus ();

  operand_load_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: operation phase plus the total number of elements loaded (0..2*ELEMS).
  int           m_phase;
  int           m_loaded;
  logic [W-1:0] m_last;
  logic         m_wen;
  logic         m_sel;
  int           m_addr;
  logic [W-1:0] m_data;

  logic         cur_be, cur_en, cur_cl, cur_ad, cur_rp;
  logic [W-1:0] cur_op;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_loaded = 0;
    m_last   = '0;
    m_wen    = 1'b0;
    m_sel    = 1'b0;
    m_addr   = 0;
    m_data   = '0;
  endtask

  function automatic int exp_state();
    if (m_phase == 1)
      return (m_loaded < ELEMS) ? 1 : 2;
    return m_phase;
  endfunction

  task automatic model_step();
    logic rep;
    rep   = cur_rp && REPEAT_ON;
    m_wen = 1'b0;
    if (rst) begin
      model_reset();
    end else if (cur_cl) begin
      m_phase  = 0;
      m_loaded = 0;
    end else begin
      case (m_phase)
        0: if (cur_be) begin m_phase = 1; m_loaded = 0; end
        1: if (cur_en || rep) begin
             m_wen  = 1'b1;
             m_sel  = (m_loaded >= ELEMS);
             m_addr = m_loaded % ELEMS;
             m_data = cur_en ? cur_op : m_last;
             if (cur_en) m_last = cur_op;
             m_loaded++;
             if (m_loaded == 2 * ELEMS) m_phase = 3;
           end
        3: m_phase = 4;
        4: if (cur_ad) m_phase = 5;
        5: if (cur_be) begin m_phase = 1; m_loaded = 0; end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic check_all();
    check_output("wr_en",        32'(bus.wr_en),        32'(m_wen));
    check_output("wr_sel",       32'(bus.wr_sel),       32'(m_sel));
    check_output("wr_addr",      32'(bus.wr_addr),      32'(m_addr));
    check_output("wr_data",      32'(bus.wr_data),      32'(m_data));
    check_output("alu_start",    32'(bus.alu_start),    32'(m_phase == 3));
    check_output("result_valid", 32'(bus.result_valid), 32'(m_phase == 5));
    check_output("busy",         32'(bus.busy),         32'(m_phase != 0));
    check_output("state_o",      32'(bus.state_o),      32'(exp_state()));
  endtask

  task automatic drive_inputs();
    bus.begin_op = cur_be;
    bus.enter    = cur_en;
    bus.clear    = cur_cl;
    bus.alu_done = cur_ad;
    bus.op_in    = cur_op;
`ifdef OPSEQ_REPEAT_EN
    bus.repeat_last = cur_rp;
`endif
  endtask

  // One clock of stimulus: drive at negedge, step the model at posedge, compare 1ns later.
  task automatic apply_stimulus(input logic be, input logic en, input logic cl,
                                input logic ad, input logic rp, input logic [W-1:0] op);
    @(negedge clk);
    cur_be = be; cur_en = en; cur_cl = cl; cur_ad = ad; cur_rp = rp; cur_op = op;
    drive_inputs();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    cur_be = 0; cur_en = 0; cur_cl = 0; cur_ad = 0; cur_rp = 0;
    drive_inputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, '0);
  endtask

  task automatic enter_values(input int n, input int first);
    for (int i = 0; i < n; i++) apply_stimulus(0, 1, 0, 0, 0, W'(first + i));
  endtask

  initial begin
    rst = 1'b1;
    cur_be = 0; cur_en = 0; cur_cl = 0; cur_ad = 0; cur_rp = 0; cur_op = '0;
    drive_inputs();
    model_reset();

    // Reset held with enter pulses: everything stays 0.
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0, W'(9'h1FF));
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 1, 0, 0, 0, W'(9'h055));

    // Full operation: A gets 1..9, B gets 10..18, ALU done 5 cycles after WAIT entry.
    apply_stimulus(1, 0, 0, 0, 0, '0);
    enter_values(ELEMS, 1);
    enter_values(ELEMS, 10);
    idle_cycles(6);
    apply_stimulus(0, 0, 0, 1, 0, '0);
    idle_cycles(3);
    apply_stimulus(1, 0, 0, 0, 0, '0);
    check_output("back_to_back_state", 32'(bus.state_o), 32'd1);

    // Clear together with enter in LOAD_B at idx 4: no write, back to IDLE.
    enter_values(ELEMS + 4, 20);
    apply_stimulus(0, 1, 1, 0, 0, W'(9'h0AA));
    check_output("clear_no_write", 32'(bus.wr_en), 32'd0);
    apply_stimulus(1, 0, 0, 0, 0, '0);
    apply_stimulus(0, 1, 0, 0, 0, W'(9'h077));
    check_output("restart_addr", 32'(bus.wr_addr), 32'd0);

    // Ignored events: alu_done in LOAD_A, enter and begin_op in WAIT.
    apply_stimulus(0, 0, 0, 1, 0, '0);
    enter_values(2 * ELEMS - 1, 40);
    idle_cycles(2);
    apply_stimulus(0, 1, 0, 0, 0, W'(9'h123));
    apply_stimulus(1, 0, 0, 0, 0, '0);
    apply_stimulus(0, 0, 0, 1, 0, '0);
    idle_cycles(2);
    apply_stimulus(0, 0, 1, 0, 0, '0);

    // Asynchronous reset between edges while in LOAD_A at idx 6.
    apply_stimulus(1, 0, 0, 0, 0, '0);
    enter_values(6, 100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_output("async_rst_state", 32'(bus.state_o), 32'd0);
    check_output("async_rst_busy",  32'(bus.busy),    32'd0);
    check_output("async_rst_wr_en", 32'(bus.wr_en),   32'd0);
    check_output("async_rst_data",  32'(bus.wr_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1, 0, 0, 0, 0, '0);
    apply_stimulus(0, 1, 0, 0, 0, W'(9'h0F0));
    check_output("post_rst_addr", 32'(bus.wr_addr), 32'd0);
    apply_stimulus(0, 0, 1, 0, 0, '0);

`ifdef OPSEQ_REPEAT_EN
    // Repeat of the last entered value, and enter winning over repeat_last.
    apply_stimulus(1, 0, 0, 0, 0, '0);
    apply_stimulus(0, 1, 0, 0, 0, W'(9'h1AB));
    apply_stimulus(0, 0, 0, 0, 1, W'(9'h000));
    check_output("repeat_data", 32'(bus.wr_data), 32'h1AB);
    check_output("repeat_addr", 32'(bus.wr_addr), 32'd1);
    apply_stimulus(0, 1, 0, 0, 1, W'(9'h005));
    check_output("enter_over_repeat", 32'(bus.wr_data), 32'h005);
    apply_stimulus(0, 0, 1, 0, 0, '0);
`endif

    // Random traffic, all events mixed, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom % 8) == 0,
                     ($urandom % 5) < 2,
                     ($urandom % 60) == 0,
                     ($urandom % 6) == 0,
                     ($urandom % 4) == 0,
                     W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_load_sequencer.md
Name: operand_load_sequencer

Overview:
- Controller that sequences keypad operand entry into the two 3x3 matrix operand stores (A then B), launches the matrix ALU, and holds the result-valid flag until the user acknowledges it.
- Sits between the keypad/operand-entry front end and the matrix register file / ALU.
- Owns the element index counter and the write strobes for the register file.

Parameters:
- W, 9, operand element width in bits.
- ELEMS, 9, elements per matrix (3x3); index width is $clog2(ELEMS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- begin_op  in  1  one-cycle pulse; starts a new operation from IDLE, or acknowledges a result in DONE.
- enter  in  1  one-cycle pulse; commits op_in as the current element.
- clear  in  1  one-cycle pulse; aborts the current operation.
- op_in  in  W  element value from the entry front end.
- alu_done  in  1  one-cycle pulse from the ALU; computation finished.
- wr_en  out  1  register-file write strobe (registered).
- wr_sel  out  1  write target: 0 = matrix A, 1 = matrix B.
- wr_addr  out  $clog2(ELEMS)  element index of the write.
- wr_data  out  W  element value being written.
- alu_start  out  1  one-cycle ALU launch pulse.
- result_valid  out  1  high from alu_done until acknowledged.
- busy  out  1  high in any state other than IDLE.
- state_o  out  3  current state encoding, for display/debug.

Behaviour:
- Reset: state IDLE, idx 0. All outputs 0: wr_en, wr_sel, wr_addr, wr_data, alu_start, result_valid, busy, state_o.
- Reset asserted mid-operation: immediate return to IDLE. Partially written matrices are not cleared; only the sequencer state resets.
- States and encodings: IDLE=0, LOAD_A=1, LOAD_B=2, START=3, WAIT=4, DONE=5.
- IDLE:
  - begin_op -> LOAD_A with idx=0.
  - enter is ignored.
- LOAD_A / LOAD_B, on enter:
  - Next cycle: wr_en=1 for exactly one cycle, wr_sel=0 (A) or 1 (B), wr_addr=idx, wr_data=op_in as sampled with enter.
  - Write latency is 1 cycle from enter.
  - idx increments after each write.
  - When idx==ELEMS-1 is written, idx wraps to 0 and the state advances: LOAD_A -> LOAD_B, LOAD_B -> START.
  - idx never exceeds ELEMS-1.
- START: alu_start=1 for one cycle, then unconditionally -> WAIT.
- WAIT: on alu_done -> DONE, with result_valid=1 from the following cycle.
- DONE:
  - result_valid stays 1.
  - begin_op acknowledges: result_valid=0 and state -> LOAD_A with idx=0 (back-to-back operation).
  - clear acknowledges: result_valid=0 and state -> IDLE.
- clear in any state: -> IDLE next cycle, idx=0, and no write is issued. Clear has priority over enter, begin_op and alu_done in the same cycle.
- Ignored events:
  - enter in START, WAIT or DONE.
  - begin_op in LOAD_A, LOAD_B, START or WAIT.
  - alu_done outside WAIT.
- Simultaneous enter and begin_op in IDLE: begin_op is taken and enter is dropped.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: OPSEQ_REPEAT_EN.
- When defined:
  - Extra input port repeat_last (1 bit) is present.
  - In LOAD_A/LOAD_B, a repeat_last pulse writes the last committed element value, held in an internal W-bit register, to the current idx. It has the same timing and index advance as enter.
  - The last-value register resets to 0 and holds its value across the A->B transition.
  - enter takes priority over repeat_last in the same cycle.
- When undefined: the port and the register are absent, and behaviour is exactly as above.

Decomposition:
- Shared package opseq_pkg holds:
  - state_t enum with the encodings above.
  - Constants OPSEQ_W=9 and OPSEQ_ELEMS=9.
  - Matrix-select constants SEL_A=0 and SEL_B=1.
- Natural sub-module: opseq_idx_counter, a wrapping 0..ELEMS-1 counter with inc/clr and a wrap pulse. The FSM and write register stay in the top module.

Test Plan:
- Reset then idle: rst high with enter pulses -> all outputs 0, state_o=0, no wr_en.
- Full operation:
  - begin_op, then 9 enters with op_in=1..9 -> wr_en pulses with wr_sel=0, addr 0..8, data 1..9.
  - 9 more enters with op_in=10..18 -> wr_sel=1, addr 0..8.
  - Then alu_start pulses once. alu_done 5 cycles later -> result_valid=1 until begin_op, then state_o=1 (LOAD_A).
- Clear priority: in LOAD_B at idx=4, clear and enter in the same cycle -> no wr_en, state_o=0, and the next begin_op starts at A addr 0.
- Ignored events:
  - enter during WAIT -> no wr_en.
  - alu_done in LOAD_A -> state unchanged.
  - begin_op in WAIT -> ignored.
- Async reset mid-load: rst asserted between clock edges in LOAD_A at idx=6 -> outputs 0 immediately, and after release begin_op restarts at addr 0.
- With OPSEQ_REPEAT_EN defined: enter op_in=0x1AB, then repeat_last -> two writes of 0x1AB to addr 0 and 1. enter and repeat_last together with op_in=0x005 -> writes 0x005.
